irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Four-source interrupt controller that sequences the program-counter path of the 8-bit core: it latches peripheral events (keyboard scan, tone timer, etc.), applies a CPU-written mask and picks a winner by fixed priority.
- At an instruction boundary it overrides the PC next-value mux with a vector address; on return-from-interrupt it restores the saved PC.
- Sits beside the PC register; its pc_sel/pc_irq outputs feed one leg of the PC mux.

Parameters:
- PCW, 10, program-counter width; matches the 10-bit PC adder path.
- VEC_BASE, 10'h3F0, vector address of source 0; source i vectors to VEC_BASE + 4*i.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq  input  4  level requests from peripherals, synchronous to clk; bit 0 has highest priority.
- mask_we  input  1  write strobe for the mask register.
- mask_d  input  4  new mask value; 1 = source enabled.
- pc_cur  input  PCW  address of the next instruction to execute (PC register output).
- instr_boundary  input  1  core is at a fetch point and may be redirected this cycle.
- reti  input  1  return-from-interrupt decoded this cycle.
- pc_sel  output  1  1 = PC mux takes pc_irq instead of the normal next PC.
- pc_irq  output  PCW  vector address or restored return address.
- irq_active  output  1  handler in progress (TAKE, SERVICE or RETURN).
- cur_src  output  2  index of the source being serviced.
- pending  output  4  latched, not-yet-taken events.
- mask_q  output  4  current mask.

Behaviour:
- Reset, asynchronous: state=IDLE; pending, mask_q, irq_prev, saved_pc and cur_src=0; pc_sel=0, pc_irq=0, irq_active=0. Reset mid-handler abandons it with no return.
- Edge detect: irq_prev <= irq every cycle. pending[i] is set on the edge where irq[i]=1 and irq_prev[i]=0. A level held high sets pending only once.
- Masked sources still latch into pending. Unmasking later makes them eligible.
- mask_q <= mask_d when mask_we. Decisions in the same cycle use the old mask_q.
- eligible = pending & mask_q. The winner is the lowest-index set bit.
- States: IDLE, TAKE, SERVICE, RETURN.
- IDLE: if eligible != 0 and instr_boundary, then on the next edge:
  - go to TAKE;
  - cur_src <= winner;
  - saved_pc <= pc_cur;
  - pending[winner] <= 0.
  Otherwise stay. reti in IDLE is ignored.
- TAKE, exactly 1 cycle: pc_sel=1, pc_irq = VEC_BASE + {cur_src,2'b00}, modulo 2^PCW (wraps). Then go to SERVICE.
- SERVICE: pc_sel=0. No nesting; new events only latch into pending. On reti go to RETURN.
- RETURN, exactly 1 cycle: pc_sel=1, pc_irq=saved_pc. Then go to IDLE.
- pc_irq=0 whenever pc_sel=0.
- irq_active=1 in TAKE, SERVICE and RETURN; 0 in IDLE.
- Simultaneous set and clear of the same pending bit (new rising edge in the take cycle): set wins, so the event is serviced again later.
- Latency: an irq rising edge sampled at edge n sets pending at n. With a mask bit set and instr_boundary=1, TAKE starts at edge n+1; pc_sel is high during cycle n+1..n+2.
- Back-to-back: after RETURN, the next eligible source can be taken from IDLE on the following boundary, giving a minimum 1 IDLE cycle between handlers.
- All outputs are driven from registered state (Moore); no combinational path from irq to pc_sel.

Test Plan:
- Reset mid-handler: assert reset asynchronously during SERVICE -> all outputs 0 immediately, state IDLE. A subsequent reti is ignored.
- Single source: mask_q=4'b0100, pulse irq[2], pc_cur=10'h055, instr_boundary=1 -> TAKE with pc_irq=10'h3F8 and cur_src=2; pending[2] clears. reti -> RETURN with pc_irq=10'h055, then IDLE with irq_active=0.
- Priority and queuing: mask_q=4'hF, irq[3] and irq[1] rise in the same cycle -> source 1 is taken (pc_irq=10'h3F4) while pending=4'b1000 remains. After reti/RETURN and one IDLE cycle, source 3 is taken (pc_irq=10'h3FC).
- Masking: mask_q=0, pulse irq[0] -> pending=4'b0001, no TAKE. Write mask_d=4'b0001 -> TAKE begins the cycle after mask_q updates.
- Boundary gating and held level: eligible pending with instr_boundary=0 for 5 cycles -> no TAKE until boundary=1. irq[0] held high for 20 cycles -> exactly one handler.
- Set/clear collision and wrap: a new irq[2] rising edge in the TAKE-decision cycle for source 2 -> pending[2] stays 1 and is retaken after RETURN. With VEC_BASE=10'h3FC, source 1 -> pc_irq=10'h000.

Source files
------------

// File: rtl/irq_sequencer.sv
// Purpose: four-source interrupt sequencer that drives one leg of the 8-bit core's PC mux.
//          Latches rising edges of irq[], gates them with mask_q and picks the lowest index.
//          Redirects the PC to a vector at an instruction boundary and restores the saved PC on reti.
// Latency: an irq edge latches into pending on edge n; with the source enabled and instr_boundary=1,
//          TAKE starts on edge n+1. TAKE and RETURN each last one cycle.
// Backpressure: none. The core holds off redirection by keeping instr_boundary low. Events that
//          arrive while a handler is running wait in pending.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   irq[3:0]            level requests, bit 0 highest priority
//   mask_we, mask_d     mask register write (1 = source enabled)
//   pc_cur              PC register output; saved as the return address
//   instr_boundary      core may be redirected this cycle
//   reti                return-from-interrupt decoded
//   pc_sel, pc_irq      PC mux override and its address (pc_irq = 0 when pc_sel = 0)
//   irq_active, cur_src handler in progress and the source being serviced
//   pending, mask_q     latched events and the current mask
module irq_sequencer #(
  parameter int             PCW      = 10,
  parameter logic [PCW-1:0] VEC_BASE = 10'h3F0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     irq,
  input  logic           mask_we,
  input  logic [3:0]     mask_d,
  input  logic [PCW-1:0] pc_cur,
  input  logic           instr_boundary,
  input  logic           reti,
  output logic           pc_sel,
  output logic [PCW-1:0] pc_irq,
  output logic           irq_active,
  output logic [1:0]     cur_src,
  output logic [3:0]     pending,
  output logic [3:0]     mask_q
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAKE    = 2'd1,
    S_SERVICE = 2'd2,
    S_RETURN  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_pending;
  logic [3:0]     r_mask;
  logic [3:0]     r_irq_prev;
  logic [PCW-1:0] r_saved_pc;
  logic [1:0]     r_cur_src;

  logic [3:0]     w_eligible;
  logic [1:0]     w_winner;
  logic           w_take;
  logic [3:0]     w_set;
  logic [3:0]     w_clr;

  assign w_eligible = r_pending & r_mask;
  assign w_set      = irq & ~r_irq_prev;

  // Fixed priority: the lowest set bit wins.
  always_comb begin
    w_winner = 2'd0;
    if (w_eligible[0])      w_winner = 2'd0;
    else if (w_eligible[1]) w_winner = 2'd1;
    else if (w_eligible[2]) w_winner = 2'd2;
    else if (w_eligible[3]) w_winner = 2'd3;
  end

  assign w_take = (r_state == S_IDLE) && (w_eligible != 4'd0) && instr_boundary;
  assign w_clr  = w_take ? (4'b0001 << w_winner) : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 4'd0;
      r_mask     <= 4'd0;
      r_irq_prev <= 4'd0;
      r_saved_pc <= '0;
      r_cur_src  <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= irq;
      // A fresh edge on the bit being taken wins over its clear, so it is serviced again later.
      r_pending  <= (r_pending & ~w_clr) | w_set;
      // The take decision above reads the old mask, so the new value takes effect next cycle.
      if (mask_we) r_mask <= mask_d;
      if (w_take) begin
        r_cur_src  <= w_winner;
        r_saved_pc <= pc_cur;
      end
    end
  end

  // Next state and Moore outputs, decoded from registered state only.
  always_comb begin
    w_state_nxt = r_state;
    pc_sel      = 1'b0;
    pc_irq      = '0;
    irq_active  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) w_state_nxt = S_TAKE;
      end
      S_TAKE: begin
        pc_sel      = 1'b1;
        pc_irq      = VEC_BASE + PCW'({r_cur_src, 2'b00});
        irq_active  = 1'b1;
        w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        irq_active = 1'b1;
        if (reti) w_state_nxt = S_RETURN;
      end
      S_RETURN: begin
        pc_sel      = 1'b1;
        pc_irq      = r_saved_pc;
        irq_active  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cur_src = r_cur_src;
  assign pending = r_pending;
  assign mask_q  = r_mask;

endmodule

// File: tb/tb_irq_sequencer.sv
// Purpose: directed bench for irq_sequencer; a vector table plus hand-written multi-cycle sequences.
// Latency: inputs are applied 1 time unit after a rising edge. Outputs are checked 1 unit after the next edge.
// Backpressure: not applicable.
module tb_irq_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_d;
  logic [9:0] pc_cur;
  logic       instr_boundary;
  logic       reti;

  logic       pc_sel,  pc_sel2;
  logic [9:0] pc_irq,  pc_irq2;
  logic       irq_active, irq_active2;
  logic [1:0] cur_src, cur_src2;
  logic [3:0] pending, pending2;
  logic [3:0] mask_q,  mask_q2;

  irq_sequencer #(.PCW(10), .VEC_BASE(10'h3F0)) u_dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_d(mask_d),
    .pc_cur(pc_cur), .instr_boundary(instr_boundary), .reti(reti),
    .pc_sel(pc_sel), .pc_irq(pc_irq), .irq_active(irq_active),
    .cur_src(cur_src), .pending(pending), .mask_q(mask_q)
  );

  // A second instance with a vector base near the top of the address space exercises wrap.
  irq_sequencer #(.PCW(10), .VEC_BASE(10'h3FC)) u_wrap (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_d(mask_d),
    .pc_cur(pc_cur), .instr_boundary(instr_boundary), .reti(reti),
    .pc_sel(pc_sel2), .pc_irq(pc_irq2), .irq_active(irq_active2),
    .cur_src(cur_src2), .pending(pending2), .mask_q(mask_q2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [3:0] md;
    logic [9:0] pc;
    logic       bnd;
    logic       reti;
    logic       e_sel;
    logic [9:0] e_pc;
    logic [9:0] e_pc2;
    logic       e_act;
    logic [1:0] e_src;
    logic [3:0] e_pend;
    logic [3:0] e_mask;
  } vec_t;

  vec_t vecs[64];
  int   nv    = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [3:0] i_irq, input logic we, input logic [3:0] md,
                     input logic [9:0] pc, input logic bnd, input logic rt,
                     input logic sel, input logic [9:0] epc, input logic [9:0] epc2,
                     input logic act, input logic [1:0] src, input logic [3:0] pend,
                     input logic [3:0] msk);
    vecs[nv] = '{i_irq, we, md, pc, bnd, rt, sel, epc, epc2, act, src, pend, msk};
    nv++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] i_irq, input logic we, input logic [3:0] md,
                       input logic [9:0] pc, input logic bnd, input logic rt);
    irq = i_irq; mask_we = we; mask_d = md; pc_cur = pc; instr_boundary = bnd; reti = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int takes;

  initial begin
    drive(4'd0, 1'b0, 4'd0, 10'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #12;
    chk("reset pc_sel", pc_sel, 0);
    chk("reset pc_irq", pc_irq, 0);
    chk("reset irq_active", irq_active, 0);
    chk("reset pending", pending, 0);
    chk("reset mask_q", mask_q, 0);
    chk("reset cur_src", cur_src, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    //   irq we md  pc      bnd rt  sel pc      pc2     act src pend mask
    // single source 2
    add(4'h0,1,4'h4,10'h000,1,0,  0,10'h000,10'h000,0,2'd0,4'h0,4'h4);
    add(4'h4,0,4'h0,10'h000,1,0,  0,10'h000,10'h000,0,2'd0,4'h4,4'h4);
    add(4'h0,0,4'h0,10'h055,1,0,  1,10'h3F8,10'h004,1,2'd2,4'h0,4'h4);
    add(4'h0,0,4'h0,10'h3F8,0,0,  0,10'h000,10'h000,1,2'd2,4'h0,4'h4);
    add(4'h0,0,4'h0,10'h3F9,0,0,  0,10'h000,10'h000,1,2'd2,4'h0,4'h4);
    add(4'h0,0,4'h0,10'h3FA,0,1,  1,10'h055,10'h055,1,2'd2,4'h0,4'h4);
    add(4'h0,0,4'h0,10'h055,1,0,  0,10'h000,10'h000,0,2'd2,4'h0,4'h4);
    // priority and queuing: sources 1 and 3 together
    add(4'h0,1,4'hF,10'h056,0,0,  0,10'h000,10'h000,0,2'd2,4'h0,4'hF);
    add(4'hA,0,4'h0,10'h057,0,0,  0,10'h000,10'h000,0,2'd2,4'hA,4'hF);
    add(4'h0,0,4'h0,10'h100,1,0,  1,10'h3F4,10'h000,1,2'd1,4'h8,4'hF);
    add(4'h0,0,4'h0,10'h3F4,1,0,  0,10'h000,10'h000,1,2'd1,4'h8,4'hF);
    add(4'h0,0,4'h0,10'h3F5,1,1,  1,10'h100,10'h100,1,2'd1,4'h8,4'hF);
    add(4'h0,0,4'h0,10'h100,1,0,  0,10'h000,10'h000,0,2'd1,4'h8,4'hF);
    add(4'h0,0,4'h0,10'h200,1,0,  1,10'h3FC,10'h008,1,2'd3,4'h0,4'hF);
    add(4'h0,0,4'h0,10'h3FC,0,0,  0,10'h000,10'h000,1,2'd3,4'h0,4'hF);
    add(4'h0,0,4'h0,10'h3FD,0,1,  1,10'h200,10'h200,1,2'd3,4'h0,4'hF);
    add(4'h0,0,4'h0,10'h200,0,0,  0,10'h000,10'h000,0,2'd3,4'h0,4'hF);
    // masked source 0, enabled later
    add(4'h0,1,4'h0,10'h201,1,0,  0,10'h000,10'h000,0,2'd3,4'h0,4'h0);
    add(4'h1,0,4'h0,10'h202,1,0,  0,10'h000,10'h000,0,2'd3,4'h1,4'h0);
    add(4'h0,0,4'h0,10'h203,1,0,  0,10'h000,10'h000,0,2'd3,4'h1,4'h0);
    add(4'h0,1,4'h1,10'h204,1,0,  0,10'h000,10'h000,0,2'd3,4'h1,4'h1);
    add(4'h0,0,4'h0,10'h123,1,0,  1,10'h3F0,10'h3FC,1,2'd0,4'h0,4'h1);
    add(4'h0,0,4'h0,10'h3F0,0,0,  0,10'h000,10'h000,1,2'd0,4'h0,4'h1);
    add(4'h0,0,4'h0,10'h3F1,0,1,  1,10'h123,10'h123,1,2'd0,4'h0,4'h1);
    add(4'h0,0,4'h0,10'h123,0,0,  0,10'h000,10'h000,0,2'd0,4'h0,4'h1);
    // boundary gating: five cycles with instr_boundary=0
    add(4'h1,0,4'h0,10'h124,0,0,  0,10'h000,10'h000,0,2'd0,4'h1,4'h1);
    for (int k = 0; k < 4; k++)
      add(4'h0,0,4'h0,10'h124,0,0,0,10'h000,10'h000,0,2'd0,4'h1,4'h1);
    add(4'h0,0,4'h0,10'h0AA,1,0,  1,10'h3F0,10'h3FC,1,2'd0,4'h0,4'h1);
    add(4'h0,0,4'h0,10'h3F0,0,0,  0,10'h000,10'h000,1,2'd0,4'h0,4'h1);
    add(4'h0,0,4'h0,10'h3F1,0,1,  1,10'h0AA,10'h0AA,1,2'd0,4'h0,4'h1);
    add(4'h0,0,4'h0,10'h0AA,0,0,  0,10'h000,10'h000,0,2'd0,4'h0,4'h1);
    // reti while IDLE is ignored
    add(4'h0,0,4'h0,10'h0AB,1,1,  0,10'h000,10'h000,0,2'd0,4'h0,4'h1);

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].irq, vecs[i].we, vecs[i].md, vecs[i].pc, vecs[i].bnd, vecs[i].reti);
      step();
      chk($sformatf("v%0d pc_sel", i), pc_sel, vecs[i].e_sel);
      chk($sformatf("v%0d pc_irq", i), pc_irq, vecs[i].e_pc);
      chk($sformatf("v%0d wrap pc_irq", i), pc_irq2, vecs[i].e_pc2);
      chk($sformatf("v%0d irq_active", i), irq_active, vecs[i].e_act);
      chk($sformatf("v%0d cur_src", i), cur_src, vecs[i].e_src);
      chk($sformatf("v%0d pending", i), pending, vecs[i].e_pend);
      chk($sformatf("v%0d mask_q", i), mask_q, vecs[i].e_mask);
    end

    // Held level: irq[0] high for 20 cycles with reti always asserted gives exactly one handler.
    takes = 0;
    for (int k = 0; k < 26; k++) begin
      drive((k < 20) ? 4'h1 : 4'h0, 1'b0, 4'h0, 10'h050, 1'b1, 1'b1);
      step();
      if (pc_sel && pc_irq == 10'h3F0) takes++;
    end
    chk("held level take count", takes, 1);
    chk("held level pending", pending, 0);
    chk("held level idle", irq_active, 0);

    // Set/clear collision: a new irq[2] edge in the cycle that takes source 2.
    drive(4'h0, 1'b1, 4'h4, 10'h060, 1'b0, 1'b0); step();
    drive(4'h4, 1'b0, 4'h0, 10'h060, 1'b0, 1'b0); step();
    drive(4'h0, 1'b0, 4'h0, 10'h060, 1'b0, 1'b0); step();
    chk("collision pre pending", pending, 4'h4);
    drive(4'h4, 1'b0, 4'h0, 10'h061, 1'b1, 1'b0); step();
    chk("collision take pc_sel", pc_sel, 1);
    chk("collision take pc_irq", pc_irq, 10'h3F8);
    chk("collision pending kept", pending, 4'h4);
    drive(4'h0, 1'b0, 4'h0, 10'h3F8, 1'b1, 1'b0); step();
    chk("collision service", pc_sel, 0);
    drive(4'h0, 1'b0, 4'h0, 10'h3F9, 1'b1, 1'b1); step();
    chk("collision return pc_irq", pc_irq, 10'h061);
    drive(4'h0, 1'b0, 4'h0, 10'h061, 1'b1, 1'b0); step();
    chk("collision idle gap", irq_active, 0);
    drive(4'h0, 1'b0, 4'h0, 10'h062, 1'b1, 1'b0); step();
    chk("collision retake pc_irq", pc_irq, 10'h3F8);
    chk("collision retake pending", pending, 4'h0);

    // Reset mid-handler: enter SERVICE with another event pending, then reset asynchronously.
    drive(4'h2, 1'b0, 4'h0, 10'h3F8, 1'b0, 1'b0); step();
    chk("pre-reset active", irq_active, 1);
    chk("pre-reset pending", pending, 4'h2);
    #2 reset = 1'b1;
    #1;
    chk("async reset irq_active", irq_active, 0);
    chk("async reset pending", pending, 0);
    chk("async reset mask_q", mask_q, 0);
    chk("async reset cur_src", cur_src, 0);
    chk("async reset pc_sel", pc_sel, 0);
    step();
    reset = 1'b0;
    drive(4'h0, 1'b0, 4'h0, 10'h070, 1'b1, 1'b1); step();
    chk("post-reset reti pc_sel", pc_sel, 0);
    chk("post-reset reti pc_irq", pc_irq, 0);
    drive(4'h0, 1'b0, 4'h0, 10'h070, 1'b1, 1'b0); step();
    chk("post-reset reti active", irq_active, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
